// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: feeds one 4-bit slice per cycle from latched
// operands and assembles the WIDTH-bit result between valid/ready handshakes.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q;

    // Slice inputs are only live during RUN so the shared adder sees zeros otherwise.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[4*idx +: 4];
            add_b   = b_q[4*idx +: 4];
            add_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= cin;
                        idx      <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= add_sum;
                    carry           <= add_cout;
                    if (idx == LAST) begin
                        cout      <= add_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench: a behavioural 4-bit slice closes the loop around each DUT;
// expected results are queued at issue and checked by independent monitors.
module tb_nibble_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 0, cout;
    logic [15:0] a = 0, b = 0, sum;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    assign {add_cout, add_sum} = add_a + add_b + add_cin;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout));

    // 4-bit instance
    logic       d4_in_valid = 0, d4_in_ready, d4_cin = 0, d4_out_valid, d4_out_ready = 1, d4_cout;
    logic [3:0] d4_a = 0, d4_b = 0, d4_sum, d4_add_a, d4_add_b, d4_add_sum;
    logic       d4_add_cin, d4_add_cout;
    assign {d4_add_cout, d4_add_sum} = d4_add_a + d4_add_b + d4_add_cin;

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .cin(d4_cin), .add_a(d4_add_a), .add_b(d4_add_b),
        .add_cin(d4_add_cin), .add_sum(d4_add_sum), .add_cout(d4_add_cout),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .sum(d4_sum), .cout(d4_cout));

    int passed = 0, total = 0;
    logic [16:0] q16[$];
    logic [4:0]  q4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                total++;
                $display("FAIL result16: unexpected result 0x%0h with empty queue", {cout, sum});
            end else chk("result16", {15'd0, cout, sum}, {15'd0, q16.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (rst_n && d4_out_valid && d4_out_ready) begin
            if (q4.size() == 0) begin
                total++;
                $display("FAIL result4: unexpected result 0x%0h with empty queue", {d4_cout, d4_sum});
            end else chk("result4", {27'd0, d4_cout, d4_sum}, {27'd0, q4.pop_front()});
        end
    end

    task automatic start(input logic [15:0] a_i, input logic [15:0] b_i, input logic c_i,
                         input logic [16:0] exp, input bit push);
        int t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        a = a_i; b = b_i; cin = c_i; in_valid = 1;
        if (push) q16.push_back(exp);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    // Walks the RUN phase at negedges; returns latency and slice-input traces.
    task automatic run_op(input int glitch, output int lat,
                          output logic [3:0] cin_tr, output logic [15:0] a_tr);
        lat = 0; cin_tr = 0; a_tr = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            if (lat < 4) begin cin_tr[lat] = add_cin; a_tr[4*lat +: 4] = add_a; end
            if (lat == glitch) begin #1 in_valid = 1; a = 16'hAAAA; end
            else if (lat == glitch + 1) begin #1 in_valid = 0; end
            lat++;
            @(negedge clk);
        end
        if (lat >= 20) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        logic [3:0]  ctr;
        logic [15:0] atr;
        logic [15:0] held;

        // reset state
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_sum", {16'd0, sum}, 0);
        chk("rst_cout", {31'd0, cout}, 0);
        chk("rst_add_a", {28'd0, add_a}, 0);
        chk("rst_add_cin", {31'd0, add_cin}, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("in_ready_after_release", {31'd0, in_ready}, 1);

        // 1: carry ripple through all nibbles
        out_ready = 1;
        start(16'hFFFF, 16'h0001, 0, 17'h1_0000, 1);
        run_op(-1, lat, ctr, atr);
        chk("t1_latency", lat, 4);
        chk("t1_cin_trace", {28'd0, ctr}, 32'hE);
        @(posedge clk); #1;

        // 2: carry-in only enters nibble 0
        start(16'h1234, 16'h4321, 1, 17'h0_5556, 1);
        run_op(-1, lat, ctr, atr);
        chk("t2_latency", lat, 4);
        chk("t2_cin_trace", {28'd0, ctr}, 32'h1);
        chk("t2_add_a_trace", {16'd0, atr}, 32'h1234);
        @(posedge clk); #1;

        // 3: consumer stalls for three cycles
        out_ready = 0;
        start(16'h00FF, 16'h0001, 0, 17'h0_0100, 1);
        run_op(-1, lat, ctr, atr);
        held = sum;
        for (int i = 0; i < 3; i++) begin
            chk("t3_out_valid_held", {31'd0, out_valid}, 1);
            chk("t3_sum_held", {16'd0, sum}, 32'h0100);
            chk("t3_in_ready_low", {31'd0, in_ready}, 0);
            @(negedge clk);
        end
        chk("t3_sum_stable", {16'd0, sum}, {16'd0, held});
        @(posedge clk); #1 out_ready = 1;
        @(posedge clk); #1;
        chk("t3_out_valid_drop", {31'd0, out_valid}, 0);
        chk("t3_in_ready_back", {31'd0, in_ready}, 1);

        // 4: in_valid during RUN is ignored
        start(16'h0F0F, 16'h00F1, 0, 17'h0_1000, 1);
        run_op(1, lat, ctr, atr);
        chk("t4_latency", lat, 4);
        chk("t4_add_a_trace", {16'd0, atr}, 32'h0F0F);
        in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t4_no_extra_output", {31'd0, out_valid}, 0);

        // 5: reset while idx==2
        start(16'h1111, 16'h2222, 0, 17'h0, 0);
        repeat (3) @(negedge clk);
        chk("t5_partial_sum", {16'd0, sum}, 32'h0033);
        chk("t5_add_a_idx2", {28'd0, add_a}, 32'h1);
        #1 rst_n = 0;
        #1;
        chk("t5_out_valid", {31'd0, out_valid}, 0);
        chk("t5_sum", {16'd0, sum}, 0);
        chk("t5_cout", {31'd0, cout}, 0);
        chk("t5_add_a", {28'd0, add_a}, 0);
        chk("t5_in_ready", {31'd0, in_ready}, 0);
        @(negedge clk); rst_n = 1;
        start(16'h8000, 16'h8000, 0, 17'h1_0000, 1);
        run_op(-1, lat, ctr, atr);
        chk("t5_latency", lat, 4);
        @(posedge clk); #1;

        // 6: WIDTH=4 instance
        begin
            int t = 0;
            while (!d4_in_ready && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) chk("d4_in_ready_timeout", 32'd0, 32'd1);
            d4_a = 4'h9; d4_b = 4'h8; d4_cin = 1; d4_in_valid = 1;
            q4.push_back(5'h12);
            @(posedge clk); #1 d4_in_valid = 0;
            lat = 0;
            @(negedge clk);
            while (!d4_out_valid && lat < 20) begin lat++; @(negedge clk); end
            chk("t6_latency", lat, 1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue16_empty", q16.size(), 0);
        chk("queue4_empty", q4.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
